// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types and constants for the cluster power sequencer.
// The state encoding is visible to software through state_o.
package cluster_pwr_seq_pkg;

  localparam int unsigned CNT_W = 16;
  localparam logic [63:0] BOOT_ADDR_RST_DEF = 64'h1C00_8080;

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_PWR_UP   = 4'd1,
    ST_RST_HOLD = 4'd2,
    ST_BOOT     = 4'd3,
    ST_ON       = 4'd4,
    ST_DRAIN    = 4'd5,
    ST_CLK_OFF  = 4'd6,
    ST_PWR_DN   = 4'd7
  } state_e;

  // A counter loaded with N-1 reaches zero in the N-th cycle of its phase.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/cluster_pwr_seq_cnt.sv
// Loadable down-counter with a zero flag; decrement stops at zero.
module cluster_pwr_seq_cnt
  import cluster_pwr_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power/reset/boot sequencer driven by fabric-controller requests.
// All control outputs are registered copies of a decode of the next state.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int unsigned PWR_SETTLE    = 16,
  parameter int unsigned RST_HOLD      = 8,
  parameter int unsigned IDLE_STABLE   = 4,
  parameter int unsigned IDLE_TIMEOUT  = 1000,
  parameter logic [63:0] BOOT_ADDR_RST = BOOT_ADDR_RST_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        test_mode_i,
  input  logic        req_valid_i,
  input  logic        req_on_i,
  input  logic [63:0] req_boot_addr_i,
  output logic        req_ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [3:0]  state_o,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o
);

  localparam logic [CNT_W-1:0] LD_SETTLE  = cnt_load(PWR_SETTLE);
  localparam logic [CNT_W-1:0] LD_RST     = cnt_load(RST_HOLD);
  localparam logic [CNT_W-1:0] LD_STABLE  = cnt_load(IDLE_STABLE);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = cnt_load(IDLE_TIMEOUT);

  state_e      state_q, state_d;
  logic        pow_q, pow_d;
  logic        clk_en_q, clk_en_d;
  logic        rstn_q, rstn_d;
  logic        fetch_q, fetch_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [63:0] boot_addr_q, boot_addr_d;

  logic             ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             to_load, to_dec, to_zero;
  logic             req_fire;
  logic             drain_idle;

  assign req_fire   = req_valid_i & ready_q;
  assign drain_idle = ~cluster_busy_i & ph_zero;
  assign to_dec     = (state_q == ST_DRAIN);

  // Phase counter doubles as the idle-stable counter while draining.
  cluster_pwr_seq_cnt u_phase_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (ph_dec),
    .zero_o     (ph_zero)
  );

  cluster_pwr_seq_cnt u_timeout_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (to_load),
    .load_val_i (LD_TIMEOUT),
    .dec_i      (to_dec),
    .zero_o     (to_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_OFF;
      pow_q       <= 1'b0;
      clk_en_q    <= 1'b0;
      rstn_q      <= 1'b0;
      fetch_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      boot_addr_q <= BOOT_ADDR_RST;
    end else begin
      state_q     <= state_d;
      pow_q       <= pow_d;
      clk_en_q    <= clk_en_d;
      rstn_q      <= rstn_d;
      fetch_q     <= fetch_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      boot_addr_q <= boot_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ph_load     = 1'b0;
    ph_val      = '0;
    ph_dec      = 1'b0;
    to_load     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    boot_addr_d = boot_addr_q;
    case (state_q)
      ST_OFF: begin
        if (req_fire) begin
          if (req_on_i) begin
            state_d     = ST_PWR_UP;
            ph_load     = 1'b1;
            ph_val      = LD_SETTLE;
            boot_addr_d = req_boot_addr_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_PWR_UP: begin
        if (ph_zero) begin
          state_d = ST_RST_HOLD;
          ph_load = 1'b1;
          ph_val  = LD_RST;
        end else begin
          ph_dec = 1'b1;
        end
      end
      ST_RST_HOLD: begin
        if (ph_zero) begin
          state_d = ST_BOOT;
        end else begin
          ph_dec = 1'b1;
        end
      end
      ST_BOOT: begin
        state_d = ST_ON;
        done_d  = 1'b1;
      end
      ST_ON: begin
        if (req_fire) begin
          if (!req_on_i) begin
            state_d = ST_DRAIN;
            ph_load = 1'b1;
            ph_val  = LD_STABLE;
            to_load = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cluster_busy_i) begin
          ph_load = 1'b1;
          ph_val  = LD_STABLE;
        end else if (ph_zero) begin
          state_d = ST_CLK_OFF;
        end else begin
          ph_dec = 1'b1;
        end
        // Reaching idle in the very last allowed cycle still wins over the abort.
        if (to_zero && !drain_idle) begin
          state_d = ST_ON;
          err_d   = 1'b1;
        end
      end
      ST_CLK_OFF: begin
        state_d = ST_PWR_DN;
        ph_load = 1'b1;
        ph_val  = LD_SETTLE;
      end
      ST_PWR_DN: begin
        if (ph_zero) begin
          state_d = ST_OFF;
          done_d  = 1'b1;
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  always_comb begin
    pow_d    = 1'b0;
    clk_en_d = 1'b0;
    rstn_d   = 1'b0;
    fetch_d  = 1'b0;
    ready_d  = 1'b0;
    case (state_d)
      ST_OFF: begin
        ready_d = 1'b1;
      end
      ST_PWR_UP, ST_CLK_OFF: begin
        pow_d = 1'b1;
      end
      ST_RST_HOLD: begin
        pow_d    = 1'b1;
        clk_en_d = 1'b1;
      end
      ST_BOOT, ST_DRAIN: begin
        pow_d    = 1'b1;
        clk_en_d = 1'b1;
        rstn_d   = 1'b1;
      end
      ST_ON: begin
        pow_d    = 1'b1;
        clk_en_d = 1'b1;
        rstn_d   = 1'b1;
        fetch_d  = 1'b1;
        ready_d  = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  assign req_ready_o            = ready_q;
  assign done_o                 = done_q;
  assign err_o                  = err_q;
  assign state_o                = state_q;
  assign cluster_pow_o          = pow_q;
  assign cluster_clk_en_o       = clk_en_q | test_mode_i;
  assign cluster_rstn_o         = rstn_q;
  assign cluster_fetch_enable_o = fetch_q;
  assign cluster_boot_addr_o    = boot_addr_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq: waypoint tables for the up/down
// sequences plus hand-written busy, timeout, reset and held-request cases.
module tb_cluster_pwr_seq;

  localparam logic [3:0] S_OFF      = 4'd0;
  localparam logic [3:0] S_PWR_UP   = 4'd1;
  localparam logic [3:0] S_RST_HOLD = 4'd2;
  localparam logic [3:0] S_BOOT     = 4'd3;
  localparam logic [3:0] S_ON       = 4'd4;
  localparam logic [3:0] S_DRAIN    = 4'd5;
  localparam logic [3:0] S_CLK_OFF  = 4'd6;
  localparam logic [3:0] S_PWR_DN   = 4'd7;

  localparam logic [63:0] ADDR_RST = 64'h0000_0000_1C00_8080;
  localparam logic [63:0] ADDR_A   = 64'h0000_0000_1C00_8000;
  localparam logic [63:0] ADDR_B   = 64'hDEAD_BEEF_0000_1000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        test_mode;
  logic        req_valid;
  logic        req_on;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        done;
  logic        err;
  logic [3:0]  state;
  logic        busy;
  logic        pow;
  logic        clk_en;
  logic        rstn;
  logic        fetch;
  logic [63:0] boot_addr;

  int checks = 0;
  int failures = 0;
  logic prev_pow = 1'b0;
  logic prev_clk_en = 1'b0;

  always #5 clk = ~clk;

  cluster_pwr_seq dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .test_mode_i            (test_mode),
    .req_valid_i            (req_valid),
    .req_on_i               (req_on),
    .req_boot_addr_i        (req_addr),
    .req_ready_o            (req_ready),
    .done_o                 (done),
    .err_o                  (err),
    .state_o                (state),
    .cluster_busy_i         (busy),
    .cluster_pow_o          (pow),
    .cluster_clk_en_o       (clk_en),
    .cluster_rstn_o         (rstn),
    .cluster_fetch_enable_o (fetch),
    .cluster_boot_addr_o    (boot_addr)
  );

  typedef struct {
    bit         dn;
    int         cyc;
    logic [3:0] st;
    logic       pow;
    logic       clk_en;
    logic       rstn;
    logic       fetch;
    logic       done;
    logic       ready;
  } wp_t;

  wp_t tbl[14];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chkv({tag, " state"}, 64'(state), 64'(S_OFF));
    chk1({tag, " pow"}, pow, 1'b0);
    chk1({tag, " clk_en"}, clk_en, 1'b0);
    chk1({tag, " rstn"}, rstn, 1'b0);
    chk1({tag, " fetch"}, fetch, 1'b0);
    chk1({tag, " ready"}, req_ready, 1'b1);
    chk1({tag, " done"}, done, 1'b0);
    chk1({tag, " err"}, err, 1'b0);
    chkv({tag, " boot_addr"}, boot_addr, ADDR_RST);
  endtask

  // Advance to the next falling edge and check the output invariants there.
  task automatic next_cycle();
    @(negedge clk);
    if (rst_ni && !test_mode) begin
      if (fetch) begin
        chk1("inv fetch->rstn", rstn, 1'b1);
        chk1("inv fetch->clk_en", clk_en, 1'b1);
        chk1("inv fetch->pow", pow, 1'b1);
      end
      if (rstn) chk1("inv rstn->pow", pow, 1'b1);
      if (prev_pow && !pow) chk1("inv pow fell with clk_en", prev_clk_en, 1'b0);
      prev_pow    = pow;
      prev_clk_en = clk_en;
    end else begin
      prev_pow    = 1'b0;
      prev_clk_en = 1'b0;
    end
  endtask

  // Called on a falling edge; on return the bench sits in cycle 1 of the request.
  task automatic send(input logic on, input logic [63:0] addr);
    req_valid = 1'b1;
    req_on    = on;
    req_addr  = addr;
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic run_seq(input bit dn, input int last);
    int dones;
    dones = 0;
    for (int c = 1; c <= last; c++) begin
      if (done) dones++;
      for (int i = 0; i < 14; i++) begin
        if (tbl[i].dn == dn && tbl[i].cyc == c) begin
          chkv($sformatf("seq%0d c%0d state", dn, c), 64'(state), 64'(tbl[i].st));
          chk1($sformatf("seq%0d c%0d pow", dn, c), pow, tbl[i].pow);
          chk1($sformatf("seq%0d c%0d clk_en", dn, c), clk_en, tbl[i].clk_en);
          chk1($sformatf("seq%0d c%0d rstn", dn, c), rstn, tbl[i].rstn);
          chk1($sformatf("seq%0d c%0d fetch", dn, c), fetch, tbl[i].fetch);
          chk1($sformatf("seq%0d c%0d done", dn, c), done, tbl[i].done);
          chk1($sformatf("seq%0d c%0d ready", dn, c), req_ready, tbl[i].ready);
        end
      end
      next_cycle();
    end
    chkv($sformatf("seq%0d done pulses", dn), 64'(dones), 64'd1);
  endtask

  function automatic logic [3:0] up_state(input int c);
    if (c <= 16) return S_PWR_UP;
    if (c <= 24) return S_RST_HOLD;
    if (c == 25) return S_BOOT;
    return S_ON;
  endfunction

  initial begin
    //            dn cyc st          pow clk rstn fetch done ready
    tbl[0]  = '{1'b0,  1, S_PWR_UP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16, S_PWR_UP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 17, S_RST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 24, S_RST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 25, S_BOOT,     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 26, S_ON,       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 27, S_ON,       1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1,  1, S_DRAIN,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1,  4, S_DRAIN,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1,  5, S_CLK_OFF,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1,  6, S_PWR_DN,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 21, S_PWR_DN,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 22, S_OFF,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 23, S_OFF,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_ni    = 1'b0;
    test_mode = 1'b1;
    req_valid = 1'b0;
    req_on    = 1'b0;
    req_addr  = '0;
    busy      = 1'b0;

    // Reset state, including the test-mode clock override.
    repeat (3) @(negedge clk);
    chk1("reset clk_en under test_mode", clk_en, 1'b1);
    test_mode = 1'b0;
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    next_cycle();

    // Redundant power-down while already off.
    send(1'b0, ADDR_B);
    chk1("redundant off done", done, 1'b1);
    chkv("redundant off state", 64'(state), 64'(S_OFF));
    chk1("redundant off pow", pow, 1'b0);
    next_cycle();
    chk1("redundant off done drop", done, 1'b0);
    chkv("redundant off addr kept", boot_addr, ADDR_RST);

    // 1: power-up
    send(1'b1, ADDR_A);
    run_seq(1'b0, 27);
    chkv("t1 boot_addr", boot_addr, ADDR_A);

    // 2: power-down with the cluster idle
    send(1'b0, '0);
    run_seq(1'b1, 23);

    // 3: busy pulses every third drain cycle up to cycle 50; last at 48
    send(1'b1, ADDR_A);
    run_seq(1'b0, 27);
    send(1'b0, '0);
    for (int c = 1; c <= 72; c++) begin
      logic [3:0] exp_st;
      if (c <= 52)      exp_st = S_DRAIN;
      else if (c == 53) exp_st = S_CLK_OFF;
      else if (c <= 69) exp_st = S_PWR_DN;
      else              exp_st = S_OFF;
      chkv($sformatf("t3 c%0d state", c), 64'(state), 64'(exp_st));
      chk1($sformatf("t3 c%0d done", c), done, (c == 70) ? 1'b1 : 1'b0);
      busy = (c <= 50 && (c % 3) == 0) ? 1'b1 : 1'b0;
      next_cycle();
    end
    busy = 1'b0;

    // 4: cluster never idles -> abort back to ON after 1000 drain cycles
    send(1'b1, ADDR_A);
    run_seq(1'b0, 27);
    busy = 1'b1;
    send(1'b0, '0);
    for (int c = 1; c <= 1002; c++) begin
      chkv($sformatf("t4 c%0d state", c), 64'(state), 64'((c <= 1000) ? S_DRAIN : S_ON));
      chk1($sformatf("t4 c%0d err", c), err, (c == 1001) ? 1'b1 : 1'b0);
      chk1($sformatf("t4 c%0d done", c), done, 1'b0);
      if (c >= 1001) chk1($sformatf("t4 c%0d fetch", c), fetch, 1'b1);
      next_cycle();
    end
    busy = 1'b0;

    // 5: asynchronous reset from ON, then again in the middle of RST_HOLD
    #2 rst_ni = 1'b0;
    #1 chk_reset("t5 reset from ON");
    prev_pow = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    next_cycle();
    send(1'b1, ADDR_B);
    repeat (19) next_cycle();
    chkv("t5 c20 state", 64'(state), 64'(S_RST_HOLD));
    #2 rst_ni = 1'b0;
    #1 chk_reset("t5 reset in RST_HOLD");
    prev_pow = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    next_cycle();
    send(1'b1, ADDR_B);
    run_seq(1'b0, 27);
    chkv("t5 boot_addr", boot_addr, ADDR_B);

    // 6: second request held during power-up, accepted as redundant in ON
    send(1'b0, '0);
    run_seq(1'b1, 23);
    send(1'b1, ADDR_A);
    for (int c = 1; c <= 28; c++) begin
      if (c == 27) req_valid = 1'b0;
      chkv($sformatf("t6 c%0d state", c), 64'(state), 64'(up_state(c)));
      chk1($sformatf("t6 c%0d ready", c), req_ready, (c >= 26) ? 1'b1 : 1'b0);
      chk1($sformatf("t6 c%0d done", c), done, (c == 26 || c == 27) ? 1'b1 : 1'b0);
      if (c >= 26) chk1($sformatf("t6 c%0d fetch", c), fetch, 1'b1);
      if (c == 3) begin
        req_valid = 1'b1;
        req_on    = 1'b1;
        req_addr  = 64'h0000_0000_1234_5678;
      end
      next_cycle();
    end
    chkv("t6 boot_addr unchanged", boot_addr, ADDR_A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
